// File: rtl/breathe_pwm_gen.sv
// Multi-channel breathing-LED generator: per-channel prescaled level counters
// (triangle / saw up / saw down / hold) feeding PWM compares against a shared counter.
module breathe_pwm_gen #(
    parameter int CH               = 4,
    parameter int W                = 8,
    parameter int PRE_W            = 16,
    parameter int DEFAULT_PEAK     = 255,
    parameter int DEFAULT_PRESCALE = 1000
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CH-1:0]                       en,
    input  logic                                cfg_we,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] cfg_ch,
    input  logic [1:0]                          cfg_addr,
    input  logic [PRE_W-1:0]                    cfg_wdata,
    output logic [CH*W-1:0]                     level,
    output logic [CH-1:0]                       pwm_out,
    output logic [CH-1:0]                       peak_pulse,
    output logic [CH-1:0]                       zero_pulse
);

    localparam logic [1:0] MODE_TRI  = 2'd0;
    localparam logic [1:0] MODE_UP   = 2'd1;
    localparam logic [1:0] MODE_DN   = 2'd2;
    localparam logic [1:0] MODE_HOLD = 2'd3;
    localparam logic [1:0] ADDR_PRE  = 2'd0;
    localparam logic [1:0] ADDR_PEAK = 2'd1;
    localparam logic [1:0] ADDR_MODE = 2'd2;
    localparam logic [W-1:0]     LVL_ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [PRE_W-1:0] CNT_ONE  = {{(PRE_W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]     PEAK_RST = W'(DEFAULT_PEAK);
    localparam logic [PRE_W-1:0] PRE_RST  = PRE_W'(DEFAULT_PRESCALE);

    logic [PRE_W-1:0] prescale_q [CH];
    logic [PRE_W-1:0] prescale_d [CH];
    logic [PRE_W-1:0] cnt_q [CH];
    logic [PRE_W-1:0] cnt_d [CH];
    logic [W-1:0]     peak_q [CH];
    logic [W-1:0]     peak_d [CH];
    logic [W-1:0]     level_q [CH];
    logic [W-1:0]     level_d [CH];
    logic [1:0]       mode_q [CH];
    logic [1:0]       mode_d [CH];
    logic [CH-1:0]    dir_q, dir_d;   // 1 = descending (triangle only)
    logic [W-1:0]     pwm_cnt_q, pwm_cnt_d;
    logic [CH-1:0]    pwm_out_q, pwm_out_d;
    logic [CH-1:0]    peak_pulse_q, peak_pulse_d;
    logic [CH-1:0]    zero_pulse_q, zero_pulse_d;
    logic [CH-1:0]    wr_s, run_s, tick_s;
    logic [W-1:0]     step_level_s [CH];
    logic [CH-1:0]    step_dir_s;

    // Write-target decode and prescaler tick; a write to a channel swallows its tick.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            wr_s[i]   = cfg_we && (cfg_addr != 2'd3) && (int'(cfg_ch) == i);
            run_s[i]  = en[i] && (mode_q[i] != MODE_HOLD);
            tick_s[i] = run_s[i] && (cnt_q[i] == prescale_q[i]) && !wr_s[i];
        end
    end

    // Level and direction that a tick would produce in the current mode.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            step_level_s[i] = level_q[i];
            step_dir_s[i]   = dir_q[i];
            case (mode_q[i])
                MODE_TRI: begin
                    if (!dir_q[i]) begin
                        if (level_q[i] == peak_q[i]) begin
                            step_level_s[i] = level_q[i] - LVL_ONE;
                            step_dir_s[i]   = 1'b1;
                        end else begin
                            step_level_s[i] = level_q[i] + LVL_ONE;
                        end
                    end else begin
                        if (level_q[i] == {W{1'b0}}) begin
                            step_level_s[i] = level_q[i] + LVL_ONE;
                            step_dir_s[i]   = 1'b0;
                        end else begin
                            step_level_s[i] = level_q[i] - LVL_ONE;
                        end
                    end
                end
                MODE_UP: step_level_s[i] = (level_q[i] == peak_q[i]) ? {W{1'b0}} : level_q[i] + LVL_ONE;
                MODE_DN: step_level_s[i] = (level_q[i] == {W{1'b0}}) ? peak_q[i] : level_q[i] - LVL_ONE;
                default: step_level_s[i] = level_q[i];
            endcase
        end
    end

    // Next state: prescaler, tick-driven step with pulses, then config writes on top.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + LVL_ONE;
        for (int i = 0; i < CH; i++) begin
            prescale_d[i]   = prescale_q[i];
            peak_d[i]       = peak_q[i];
            mode_d[i]       = mode_q[i];
            level_d[i]      = level_q[i];
            dir_d[i]        = dir_q[i];
            peak_pulse_d[i] = 1'b0;
            zero_pulse_d[i] = 1'b0;
            pwm_out_d[i]    = (pwm_cnt_q < level_q[i]);
            if (!run_s[i]) begin
                cnt_d[i] = cnt_q[i];
            end else if (cnt_q[i] == prescale_q[i]) begin
                cnt_d[i] = {PRE_W{1'b0}};
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
            // With peak=0 the level is pinned at 0, so a tick must not move it.
            if (tick_s[i] && (peak_q[i] != {W{1'b0}})) begin
                level_d[i]      = step_level_s[i];
                dir_d[i]        = step_dir_s[i];
                peak_pulse_d[i] = (step_level_s[i] == peak_q[i]);
                zero_pulse_d[i] = (step_level_s[i] == {W{1'b0}});
            end else begin
                level_d[i] = level_q[i];
            end
            if (wr_s[i]) begin
                case (cfg_addr)
                    ADDR_PRE: begin
                        prescale_d[i] = cfg_wdata;
                        cnt_d[i]      = {PRE_W{1'b0}};
                    end
                    ADDR_PEAK: begin
                        peak_d[i] = cfg_wdata[W-1:0];
                        if (level_q[i] > cfg_wdata[W-1:0]) begin
                            level_d[i] = cfg_wdata[W-1:0];
                            dir_d[i]   = 1'b1;
                        end else begin
                            level_d[i] = level_q[i];
                        end
                    end
                    ADDR_MODE: begin
                        mode_d[i]  = cfg_wdata[1:0];
                        level_d[i] = {W{1'b0}};
                        dir_d[i]   = 1'b0;
                        cnt_d[i]   = {PRE_W{1'b0}};
                    end
                    default: mode_d[i] = mode_q[i];
                endcase
            end else begin
                mode_d[i] = mode_q[i];
            end
        end
    end

    // State registers; reset restores the default configuration and overrides writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                prescale_q[i] <= PRE_RST;
                cnt_q[i]      <= {PRE_W{1'b0}};
                peak_q[i]     <= PEAK_RST;
                level_q[i]    <= {W{1'b0}};
                mode_q[i]     <= MODE_TRI;
            end
            dir_q        <= {CH{1'b0}};
            pwm_cnt_q    <= {W{1'b0}};
            pwm_out_q    <= {CH{1'b0}};
            peak_pulse_q <= {CH{1'b0}};
            zero_pulse_q <= {CH{1'b0}};
        end else begin
            for (int i = 0; i < CH; i++) begin
                prescale_q[i] <= prescale_d[i];
                cnt_q[i]      <= cnt_d[i];
                peak_q[i]     <= peak_d[i];
                level_q[i]    <= level_d[i];
                mode_q[i]     <= mode_d[i];
            end
            dir_q        <= dir_d;
            pwm_cnt_q    <= pwm_cnt_d;
            pwm_out_q    <= pwm_out_d;
            peak_pulse_q <= peak_pulse_d;
            zero_pulse_q <= zero_pulse_d;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_level
        assign level[g*W +: W] = level_q[g];
    end

    assign pwm_out    = pwm_out_q;
    assign peak_pulse = peak_pulse_q;
    assign zero_pulse = zero_pulse_q;

endmodule

// File: tb/tb_breathe_pwm_gen.sv
// Bench for breathe_pwm_gen: directed scenarios plus random config traffic, all
// checked every cycle against a phase/modulo-arithmetic reference model.
module tb_breathe_pwm_gen;

    localparam int CH    = 3;
    localparam int W     = 8;
    localparam int PRE_W = 16;
    localparam int CW    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CH-1:0]    en = '0;
    logic             cfg_we = 1'b0;
    logic [CW-1:0]    cfg_ch = '0;
    logic [1:0]       cfg_addr = '0;
    logic [PRE_W-1:0] cfg_wdata = '0;
    wire  [CH*W-1:0]  level;
    wire  [CH-1:0]    pwm_out, peak_pulse, zero_pulse;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    breathe_pwm_gen #(
        .CH(CH), .W(W), .PRE_W(PRE_W), .DEFAULT_PEAK(255), .DEFAULT_PRESCALE(1000)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .level(level),
        .pwm_out(pwm_out), .peak_pulse(peak_pulse), .zero_pulse(zero_pulse)
    );

    // Reference model: triangle tracked as a phase in 0..2*peak-1, saws as modulo counts.
    int m_level [CH];
    int m_phase [CH];
    int m_cnt [CH];
    int m_pre [CH];
    int m_peak [CH];
    int m_mode [CH];
    bit m_clamped [CH];
    int m_pwm;
    logic [CH-1:0] e_pwm, e_pp, e_zp;

    function automatic int tri_level(input int ph, input int pk);
        return (ph <= pk) ? ph : 2 * pk - ph;
    endfunction

    function automatic void m_step();
        bit wr, tick, desc;
        int wd, np;
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                m_level[i] = 0; m_phase[i] = 0; m_cnt[i] = 0; m_pre[i] = 1000;
                m_peak[i] = 255; m_mode[i] = 0; m_clamped[i] = 1'b0;
            end
            m_pwm = 0; e_pwm = '0; e_pp = '0; e_zp = '0;
            return;
        end
        for (int i = 0; i < CH; i++) begin
            wr = cfg_we && (cfg_addr != 2'd3) && (int'(cfg_ch) == i);
            wd = int'(cfg_wdata);
            e_pwm[i] = (m_pwm < m_level[i]);
            e_pp[i] = 1'b0;
            e_zp[i] = 1'b0;
            if (en[i] && m_mode[i] != 3) begin
                tick = (m_cnt[i] == m_pre[i]);
                m_cnt[i] = tick ? 0 : m_cnt[i] + 1;
                if (tick && !wr && m_peak[i] > 0) begin
                    if (m_mode[i] == 0) begin
                        m_phase[i] = (m_phase[i] + 1) % (2 * m_peak[i]);
                        m_level[i] = tri_level(m_phase[i], m_peak[i]);
                    end else if (m_mode[i] == 1) begin
                        m_level[i] = (m_level[i] + 1) % (m_peak[i] + 1);
                    end else begin
                        m_level[i] = (m_level[i] + m_peak[i]) % (m_peak[i] + 1);
                    end
                    m_clamped[i] = 1'b0;
                    e_pp[i] = (m_level[i] == m_peak[i]);
                    e_zp[i] = (m_level[i] == 0);
                end
            end
            if (wr) begin
                if (cfg_addr == 2'd0) begin
                    m_pre[i] = wd; m_cnt[i] = 0;
                end else if (cfg_addr == 2'd1) begin
                    np = wd % 256;
                    desc = (m_phase[i] > m_peak[i]) || m_clamped[i];
                    if (m_level[i] > np) begin
                        m_level[i] = np; m_phase[i] = np; m_clamped[i] = 1'b1;
                    end else if (desc) begin
                        m_phase[i] = (np == 0) ? 0 : (2 * np - m_level[i]) % (2 * np);
                        m_clamped[i] = (m_level[i] == np) && (np > 0);
                    end else begin
                        m_phase[i] = m_level[i]; m_clamped[i] = 1'b0;
                    end
                    m_peak[i] = np;
                end else begin
                    m_mode[i] = wd % 4; m_level[i] = 0; m_phase[i] = 0;
                    m_cnt[i] = 0; m_clamped[i] = 1'b0;
                end
            end
        end
        m_pwm = (m_pwm + 1) % 256;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        m_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < CH; i++) chk("level", 32'(level[i*W +: W]), 32'(m_level[i]));
        chk("pwm_out", 32'(pwm_out), 32'(e_pwm));
        chk("peak_pulse", 32'(peak_pulse), 32'(e_pp));
        chk("zero_pulse", 32'(zero_pulse), 32'(e_zp));
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic wr(input int ch, input int addr, input int data);
        cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_addr = 2'(addr); cfg_wdata = PRE_W'(data);
        cyc();
        cfg_we = 1'b0;
    endtask

    function automatic int lvl(input int ch);
        return int'(level[ch*W +: W]);
    endfunction

    initial begin
        int seq [10];
        int hi, op;
        seq = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2};

        // Reset state
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_outs", {29'd0, pwm_out | peak_pulse | zero_pulse}, 32'd0);

        // Triangle, peak 4, prescale 0
        wr(0, 1, 4); wr(0, 0, 0); wr(0, 2, 0);
        en = 3'b001;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("t1_seq", 32'(lvl(0)), 32'(seq[k]));
            chk("t1_peak", 32'(peak_pulse[0]), 32'(seq[k] == 4));
            chk("t1_zero", 32'(zero_pulse[0]), 32'(seq[k] == 0));
        end

        // Saw up with prescale 2, then an enable gap
        wr(1, 0, 2); wr(1, 1, 3); wr(1, 2, 1);
        en = 3'b011;
        run(7);
        en[1] = 1'b0;
        run(5);
        en[1] = 1'b1;
        run(9);

        // Peak lowered below an ascending level
        wr(2, 0, 0); wr(2, 1, 255); wr(2, 2, 0);
        en[2] = 1'b1;
        run(200);
        chk("t3_pre", 32'(lvl(2)), 32'd200);
        wr(2, 1, 100);
        chk("t3_clamp", 32'(lvl(2)), 32'd100);
        chk("t3_nopulse", 32'(peak_pulse[2]), 32'd0);
        cyc();
        chk("t3_desc", 32'(lvl(2)), 32'd99);

        // PWM duty at level 64 and at level 0
        en = 3'b000;
        wr(0, 0, 0); wr(0, 1, 255); wr(0, 2, 1);
        en[0] = 1'b1;
        run(64);
        en = 3'b000;
        chk("t4_level", 32'(lvl(0)), 32'd64);
        hi = 0;
        repeat (256) begin cyc(); hi += int'(pwm_out[0]); end
        chk("t4_duty64", 32'(hi), 32'd64);
        wr(0, 2, 3);
        en[0] = 1'b1;
        hi = 0;
        repeat (300) begin cyc(); hi += int'(pwm_out[0]); end
        chk("t4_duty0", 32'(hi), 32'd0);

        // Same-cycle write vs tick, and an out-of-range channel
        en = 3'b000;
        wr(0, 2, 0); wr(1, 0, 0); wr(1, 1, 200); wr(1, 2, 0);
        en = 3'b011;
        run(10);
        wr(1, 1, 50);
        chk("t5_ch1_hold", 32'(lvl(1)), 32'd10);
        chk("t5_ch0_step", 32'(lvl(0)), 32'd11);
        wr(3, 1, 0);
        chk("t5_bad_ch1", 32'(lvl(1)), 32'd11);
        chk("t5_bad_ch0", 32'(lvl(0)), 32'd12);

        // Reset with a simultaneous write, then default prescale/peak
        en = 3'b111;
        run(20);
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_addr = 2'd1; cfg_wdata = 16'd5;
        rst = 1'b1;
        cyc();
        rst = 1'b0; cfg_we = 1'b0;
        chk("t6_levels", 32'(level), 32'd0);
        run(1000);
        chk("t6_still0", 32'(lvl(0)), 32'd0);
        cyc();
        chk("t6_first", 32'(lvl(0)), 32'd1);

        // Random configuration traffic
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 15) == 0) en = CH'($urandom);
            rst = ($urandom_range(0, 799) == 0);
            cfg_we = 1'b0;
            if ($urandom_range(0, 5) == 0) begin
                op = int'($urandom_range(0, 3));
                cfg_we = 1'b1;
                cfg_ch = CW'($urandom_range(0, 3));
                cfg_addr = 2'(op);
                if (op == 0) cfg_wdata = PRE_W'($urandom_range(0, 3));
                else if (op == 1) cfg_wdata = ($urandom_range(0, 1) == 1) ? PRE_W'($urandom_range(0, 6))
                                                                          : PRE_W'($urandom);
                else cfg_wdata = PRE_W'($urandom);
            end
            cyc();
        end
        cfg_we = 1'b0;
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
